// File: rtl/dxm_sync_pipe.sv
// Multi-bit synchroniser/delay pipeline with clock enable, settle flag and edge pulses.
// Define DXM_SYNC_FILTER_EN to add a whole-vector stability filter in front of q.
module dxm_sync_pipe #(
    parameter int               WIDTH      = 1,
    parameter int               STAGES     = 2,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter int               FILTER_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             settled
);

`ifdef DXM_SYNC_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    localparam int            SETTLE_MAX = STAGES + (FILTER_EN ? FILTER_LEN : 0);
    localparam int            CW         = $clog2(SETTLE_MAX + 1);
    localparam logic [CW-1:0] SMAX       = CW'(SETTLE_MAX);

    logic [WIDTH-1:0] stage [STAGES];
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    settle_cnt;

    assign settled = (settle_cnt == SMAX);

`ifdef DXM_SYNC_FILTER_EN
    localparam logic [3:0] FLEN = 4'(FILTER_LEN);

    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] q_filt;
    logic [3:0]       stab_cnt;
    logic [3:0]       run_now;

    // run_now counts the current final-stage value itself, so a fresh value starts at 1
    always_comb begin
        run_now = 4'd1;
        q_next  = q_filt;
        if (stage[STAGES-1] == hold) begin
            run_now = (stab_cnt == 4'hF) ? 4'hF : stab_cnt + 4'd1;
        end
        if (run_now >= FLEN) begin
            q_next = stage[STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= RST_VAL;
            stab_cnt <= '0;
            q_filt   <= RST_VAL;
        end else if (en) begin
            hold     <= stage[STAGES-1];
            stab_cnt <= run_now;
            q_filt   <= q_next;
        end
    end

    assign q = q_filt;
`else
    always_comb begin
        q_next = stage[STAGES-2];
    end

    assign q = stage[STAGES-1];
`endif

    // Pulses compare the value q is about to take with its current value, so they line up with q
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RST_VAL;
            end
            settle_cnt <= '0;
            rise       <= '0;
            fall       <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            if (en) begin
                stage[0] <= d;
                for (int i = 1; i < STAGES; i++) begin
                    stage[i] <= stage[i-1];
                end
                if (settle_cnt != SMAX) begin
                    settle_cnt <= settle_cnt + CW'(1);
                end
                if (settled) begin
                    rise <= q_next & ~q;
                    fall <= ~q_next & q;
                end
            end
        end
    end

endmodule
